// File: rtl/demux_pkg.sv
// Shared sizing, mode encoding and pointer helper for the 1-to-4 stream demux.
package demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef logic [SEL_W-1:0] slot_idx_t;

  // Round-robin successor; the 2-bit result wraps 3 -> 0 naturally.
  function automatic slot_idx_t rr_next(input slot_idx_t p);
    return slot_idx_t'(p + slot_idx_t'(1));
  endfunction

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Stream bundle between one source and four consumers of the demux.
interface stream_demux_1_4_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]       in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   sel_mode;
  logic [SEL_W-1:0]       sel;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;

  modport master (
    output in_data, in_valid, sel_mode, sel, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel_mode, sel, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/demux_out_slot.sv
// One output register of the demux: load, drain, valid flag.
// Optional per-slot accepted-beat counter when DEMUX_CNT_EN is defined.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // A load wins over a drain so a simultaneous drain+fill keeps valid high.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && drain_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 stream demultiplexer, routing by sel or strict round-robin.
// Define DEMUX_CNT_EN to add the beat_cnt per-slot accepted-beat counters.
module stream_demux_1_4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  stream_demux_1_4_if.slave        bus
`ifdef DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]   beat_cnt
`endif
);

  mode_e                  mode_c;
  slot_idx_t              dest_c;
  slot_idx_t              rr_ptr_q, rr_ptr_d;
  logic                   in_ready_c;
  logic                   accept_c;
  logic [N_OUT-1:0]       load_c;
  logic [N_OUT-1:0]       slot_valid;
  logic [N_OUT*WIDTH-1:0] slot_data;

  // Destination decode; round-robin never skips, so a full target stalls.
  always_comb begin
    mode_c = mode_e'(bus.sel_mode);
    dest_c = (mode_c == MODE_RR) ? rr_ptr_q : bus.sel;
  end

  assign in_ready_c = rst_n & (~slot_valid[dest_c] | bus.out_ready[dest_c]);
  assign accept_c   = bus.in_valid & in_ready_c;

  always_comb begin
    load_c = '0;
    if (accept_c) begin
      load_c[dest_c] = 1'b1;
    end
  end

  // Pointer only moves on a beat accepted in round-robin mode.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_c && (mode_c == MODE_RR)) begin
      rr_ptr_d = rr_next(rr_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load_c[k]),
      .data_i  (bus.in_data),
      .drain_i (bus.out_ready[k]),
      .data_o  (slot_data[k*WIDTH +: WIDTH]),
      .valid_o (slot_valid[k])
`ifdef DEMUX_CNT_EN
      ,
      .cnt_o   (beat_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = slot_data;
  assign bus.out_valid = slot_valid;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: queue/array model checked every cycle plus directed literal checks.
module tb_stream_demux_1_4;
  import demux_pkg::*;

  localparam int unsigned W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_1_4_if #(.WIDTH(W)) bus ();

`ifdef DEMUX_CNT_EN
  logic [63:0] beat_cnt;
`endif

  stream_demux_1_4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef DEMUX_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: four slots as plain arrays, pointer as an integer.
  bit           m_valid [4];
  logic [W-1:0] m_data  [4];
  int           m_cnt   [4];
  int           m_rr;
  bit           started;
  int           md;
  bit           mrdy;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0; m_data[k] = '0; m_cnt[k] = 0;
    end
    m_rr = 0; started = 1'b0;
  end

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_valid[k] = 1'b0; m_data[k] = '0; m_cnt[k] = 0;
      end
      m_rr = 0;
    end else begin
      md   = bus.sel_mode ? m_rr : int'(bus.sel);
      mrdy = !m_valid[md] || bus.out_ready[md];
      for (int k = 0; k < 4; k++)
        if (m_valid[k] && bus.out_ready[k]) m_valid[k] = 1'b0;
      if (bus.in_valid && mrdy) begin
        m_valid[md] = 1'b1;
        m_data[md]  = bus.in_data;
        m_cnt[md]   = (m_cnt[md] + 1) % 65536;
        if (bus.sel_mode) m_rr = (m_rr + 1) % 4;
      end
    end
  end

  function automatic bit exp_ready();
    int d;
    d = bus.sel_mode ? m_rr : int'(bus.sel);
    return rst_n && (!m_valid[d] || bus.out_ready[d]);
  endfunction

  // Delivered beats as seen on the DUT outputs, in order.
  int           log_slot [$];
  logic [W-1:0] log_data [$];

  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] ed;
    if (started) begin
      for (int k = 0; k < 4; k++) begin
        ev[k] = m_valid[k];
        ed[k*8 +: 8] = m_data[k];
      end
      chk("in_ready",  64'(bus.in_ready),  64'(exp_ready()));
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("out_data",  64'(bus.out_data),  64'(ed));
      chk("rr_ptr",    64'(dut.rr_ptr_q),  64'(m_rr[1:0]));
`ifdef DEMUX_CNT_EN
      for (int k = 0; k < 4; k++)
        chk("beat_cnt", 64'(beat_cnt[k*16 +: 16]), 64'(m_cnt[k][15:0]));
`endif
      if (rst_n)
        for (int k = 0; k < 4; k++)
          if (bus.out_valid[k] && bus.out_ready[k]) begin
            log_slot.push_back(k);
            log_data.push_back(bus.out_data[k*8 +: 8]);
          end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] data, input logic mode, input logic [1:0] s);
    bit ok;
    ok = 1'b0;
    bus.in_data = data; bus.sel_mode = mode; bus.sel = s; bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", 64'(ok), 64'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp_s [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.sel = '0; bus.sel_mode = 1'b0;
    bus.out_ready = '0; rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    tick();
    rst_n = 1'b1;

    // Single beat routed by sel to slot 2
    send(8'hA5, 1'b0, 2'd2);
    @(negedge clk);
    chk("t1_valid", 64'(bus.out_valid), 64'(4'b0100));
    chk("t1_data",  64'(bus.out_data[23:16]), 64'(8'hA5));

    // Second beat to full slot 2 stalls, then drain+fill with no bubble
    tick();
    bus.in_data = 8'h3C; bus.sel = 2'd2; bus.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t2_stall_ready", 64'(bus.in_ready),  64'(0));
      chk("t2_stall_valid", 64'(bus.out_valid), 64'(4'b0100));
      chk("t2_stall_data",  64'(bus.out_data[23:16]), 64'(8'hA5));
    end
    tick();
    bus.out_ready = 4'b0100;
    @(negedge clk);
    chk("t2_ready_comb", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0; bus.out_ready = '0;
    @(negedge clk);
    chk("t2_valid", 64'(bus.out_valid), 64'(4'b0100));
    chk("t2_data",  64'(bus.out_data[23:16]), 64'(8'h3C));

    // Round-robin order 0,1,2,3,0,1
    tick();
    bus.out_ready = 4'hF;
    tick();
    log_slot.delete(); log_data.delete();
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b1, 2'd0);
    repeat (3) tick();
    chk("t3_count", 64'(log_slot.size()), 64'(6));
    for (int i = 0; i < 6 && i < log_slot.size(); i++) begin
      chk("t3_slot", 64'(log_slot[i]), 64'(exp_s[i]));
      chk("t3_data", 64'(log_data[i]), 64'(i + 1));
    end
    chk("t3_rr_ptr", 64'(dut.rr_ptr_q), 64'(2));

    // Round-robin stalls on full slot 1 and never skips to slot 2
    bus.out_ready = 4'b1101;
    send(8'h11, 1'b0, 2'd1);
    send(8'h12, 1'b1, 2'd0);
    send(8'h13, 1'b1, 2'd0);
    send(8'h14, 1'b1, 2'd0);
    bus.in_data = 8'h15; bus.sel_mode = 1'b1; bus.sel = 2'd2; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_ready", 64'(bus.in_ready),     64'(0));
      chk("t4_no_skip",     64'(bus.out_valid[2]), 64'(0));
      chk("t4_rr_hold",     64'(dut.rr_ptr_q),     64'(1));
    end
    tick();
    bus.out_ready = 4'hF;
    @(negedge clk);
    chk("t4_release", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0; bus.out_ready = '0;
    @(negedge clk);
    chk("t4_valid",  64'(bus.out_valid), 64'(4'b0010));
    chk("t4_data",   64'(bus.out_data[15:8]), 64'(8'h15));
    chk("t4_rr_ptr", 64'(dut.rr_ptr_q), 64'(2));

    // Reset mid-stream with two slots full overrides accept and drain
    tick();
    send(8'h21, 1'b0, 2'd0);
    bus.in_data = 8'h77; bus.sel_mode = 1'b0; bus.sel = 2'd2; bus.in_valid = 1'b1;
    bus.out_ready = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", 64'(bus.in_ready), 64'(0));
    tick();
    rst_n = 1'b1; bus.in_valid = 1'b0; bus.out_ready = '0;
    @(negedge clk);
    chk("t5_valid",  64'(bus.out_valid), 64'(0));
    chk("t5_rr_ptr", 64'(dut.rr_ptr_q),  64'(0));
    tick();
    send(8'h99, 1'b1, 2'd3);
    @(negedge clk);
    chk("t5_first_rr_valid", 64'(bus.out_valid), 64'(4'b0001));
    chk("t5_first_rr_data",  64'(bus.out_data[7:0]), 64'(8'h99));

`ifdef DEMUX_CNT_EN
    // 65537 beats to slot 3 wrap its counter to 1
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 4'hF; bus.sel_mode = 1'b0; bus.sel = 2'd3; bus.in_data = 8'h5A;
    bus.in_valid = 1'b1;
    repeat (65537) tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_beat_cnt", beat_cnt, {16'd1, 48'd0});
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 in_data  input  WIDTH  input payload.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the input beat this cycle.
REQ-007 sel_mode  input  1  0 = route by sel; 1 = internal round-robin.
REQ-008 sel  input  2  destination index when sel_mode=0; ignored otherwise.
REQ-009 out_data  output  4*WIDTH  packed; slot k occupies bits [k*WIDTH +: WIDTH].
REQ-010 out_valid  output  4  slot k holds a beat.
REQ-011 out_ready  input  4  consumer k takes the beat this cycle.

Function
REQ-012 A beat is accepted when in_valid=1 and in_ready=1 on a rising edge; a beat leaves slot k when out_valid[k]=1 and out_ready[k]=1.
REQ-013 Destination d = sel when sel_mode=0, else the round-robin pointer rr_ptr (2 bits).
REQ-014 in_ready = (out_valid[d]=0) or (out_ready[d]=1); the out_ready-to-in_ready combinational path is permitted; no other input-to-output combinational path exists.
REQ-015 On acceptance, slot d loads in_data and asserts out_valid[d] on the next cycle; latency is exactly 1 cycle.
REQ-016 Simultaneous drain and fill of the same slot: the slot loads the new beat and out_valid[d] stays 1 with no bubble.
REQ-017 A slot without a drain or fill holds out_data and out_valid unchanged.
REQ-018 rr_ptr advances by 1 modulo 4 (3 -> 0) only on an accepted beat in round-robin mode; it holds in sel mode and retains its value across mode changes.
REQ-019 Round-robin never skips a full slot; if slot rr_ptr is full and not draining, the input stalls, preserving strict order 0,1,2,3.
REQ-020 sel, sel_mode and in_data shall be held stable by the source while in_valid=1 and in_ready=0; the block samples them only at acceptance.
REQ-021 out_data[k] while out_valid[k]=0 is don't-care for consumers but is not cleared except by reset.
REQ-022 A slot's beat is never lost or duplicated; each beat appears on exactly one output exactly once.

Reset
REQ-023 With rst_n=0 at a rising edge: out_valid=0, out_data=0, rr_ptr=0, and any in-flight beat is discarded.
REQ-024 While rst_n=0, in_ready=0; acceptance resumes the first cycle after rst_n returns high.
REQ-025 Reset asserted mid-stream overrides any simultaneous accept or drain in that cycle.

Configuration
REQ-026 Macro DEMUX_CNT_EN: when defined, the block adds output port beat_cnt (64 bits, 4 x 16-bit packed, slot k at [k*16 +: 16]), counting beats accepted into slot k, wrapping 0xFFFF -> 0x0000, reset to 0.
REQ-027 When DEMUX_CNT_EN is undefined, beat_cnt and its counters are absent, and all other behaviour is identical.

Structure
REQ-028 Package demux_pkg holds N_OUT=4, SEL_W=2, CNT_W=16 and the mode enum (MODE_SEL=0, MODE_RR=1).
REQ-029 Sub-module demux_out_slot implements one output register (load, drain, valid flag, optional counter) and is instantiated 4 times by generate.
REQ-030 The top level holds only destination decode, in_ready generation and rr_ptr.

Verification
REQ-031 Reset, then sel_mode=0, sel=2, in_data=0xA5, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100 and slot 2 holds 0xA5; other slots remain invalid.
REQ-032 Slot 2 full, out_ready=0, second beat 0x3C to sel=2 -> in_ready=0 and stalls; raise out_ready[2] -> same-cycle accept, slot 2 holds 0x3C next cycle with no bubble.
REQ-033 sel_mode=1, out_ready=4'hF, 6 beats 0x01..0x06 -> outputs 0,1,2,3,0,1 in order; rr_ptr=2 afterwards.
REQ-034 sel_mode=1, out_ready[1]=0, slot 1 full, next beat targets slot 1 -> stall with no skip to slot 2 until out_ready[1]=1.
REQ-035 Stream in flight with two slots full, rst_n=0 for one cycle -> out_valid=0, rr_ptr=0, in_ready=0 during reset; first post-reset RR beat lands in slot 0.
REQ-036 With DEMUX_CNT_EN, 65537 beats to sel=3 -> beat_cnt slot 3 = 1 (wrapped), other slots = 0.
